// File: rtl/axil_csr_pkg.sv
// Shared constants and state types for the AXI4-Lite CSR slave.
// Word indices are addr[ADDR_W-1:2]. Response codes follow AXI encoding.
package axil_csr_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int IDX_CTRL   = 0;
  localparam int IDX_STATUS = 1;
  localparam int IDX_CFG0   = 2;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;
endpackage

// File: rtl/axil_csr_regfile.sv
// CSR storage: byte-lane merged CFG writes, START pulse, sticky DONE, combinational read mux.
// Writes land on the commit strobe; start is registered (one cycle after commit); no backpressure.
module axil_csr_regfile
  import axil_csr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_CFG = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_ctrl,
  input  logic                            wr_status,
  input  logic [NUM_CFG-1:0]              wr_cfg,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [DATA_W/8-1:0]             wr_strb,
  input  logic                            rd_ctrl,
  input  logic                            rd_status,
  input  logic [NUM_CFG-1:0]              rd_cfg,
  output logic [DATA_W-1:0]               rd_data,
  input  logic                            core_busy,
  input  logic                            core_done,
  output logic                            start,
  output logic [NUM_CFG-1:0][DATA_W-1:0]  cfg
`ifdef AXIL_CSR_IRQ_EN
  ,
  output logic                            irq
`endif
);
  localparam int NB = DATA_W / 8;

  logic [NUM_CFG-1:0][DATA_W-1:0] cfg_q;
  logic done_q;
  logic start_q;
  logic irq_en_q;
  logic start_req;
  logic done_clr;

  // START and DONE-clear live in byte lane 0; busy is sampled at commit.
  assign start_req = wr_ctrl & wr_strb[0] & wr_data[CTRL_START] & ~core_busy;
  assign done_clr  = wr_status & wr_strb[0] & wr_data[STATUS_DONE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_cfg[i] && wr_strb[b]) cfg_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
      // A same-cycle set beats the write-1-to-clear.
      done_q  <= core_done | (done_q & ~done_clr);
      start_q <= start_req;
    end
  end

`ifdef AXIL_CSR_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl && wr_strb[0]) irq_en_q <= wr_data[CTRL_IRQ_EN];
      irq_q <= irq_en_q & done_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (rd_ctrl) rd_data[CTRL_IRQ_EN] = irq_en_q;
    if (rd_status) begin
      rd_data[STATUS_BUSY] = core_busy;
      rd_data[STATUS_DONE] = done_q;
    end
    for (int i = 0; i < NUM_CFG; i++) begin
      if (rd_cfg[i]) rd_data = rd_data | cfg_q[i];
    end
  end

  assign start = start_q;
  assign cfg   = cfg_q;
endmodule

// File: rtl/axil_csr_slave.sv
// AXI4-Lite CSR slave for the matrix core; write commits 1 cycle after AW+W held, read data 1 cycle after AR.
// One outstanding write and one outstanding read; optional irq_o with AXIL_CSR_IRQ_EN.
module axil_csr_slave
  import axil_csr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_CFG = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_W-1:0]         s_axi_wdata,
  input  logic [DATA_W/8-1:0]       s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_W-1:0]         s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_W-1:0]         s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      start_o,
  output logic [NUM_CFG*DATA_W-1:0] cfg_o,
  input  logic                      core_busy_i,
  input  logic                      core_done_i
`ifdef AXIL_CSR_IRQ_EN
  ,
  output logic                      irq_o
`endif
);
  localparam int IW = ADDR_W - 2;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                ready_en;
  logic [IW-1:0]       aw_idx_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] rd_idx;
  logic wr_is_ctrl, wr_is_status, wr_mapped;
  logic rd_is_ctrl, rd_is_status, rd_mapped;
  logic [NUM_CFG-1:0] wr_is_cfg, rd_is_cfg;
  logic [DATA_W-1:0] rd_mux;
  logic [NUM_CFG-1:0][DATA_W-1:0] cfg_regs;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readies stay low during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign s_axi_awready = ready_en & ((wr_state == WR_IDLE) | (wr_state == WR_DATA));
  assign s_axi_wready  = ready_en & ((wr_state == WR_IDLE) | (wr_state == WR_ADDR));
  assign s_axi_bvalid  = (wr_state == WR_COMMIT) | (wr_state == WR_RESP);
  assign s_axi_arready = ready_en & (rd_state == RD_IDLE);
  assign s_axi_rvalid  = (rd_state == RD_DATA);

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = (wr_state == WR_COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_W-1:2];
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (ar_hs) begin
        rdata_q <= rd_mux;
        rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // B can handshake in the commit cycle itself, freeing AW/W the cycle after.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_COMMIT;
        else if (aw_hs)    wr_next = WR_ADDR;
        else if (w_hs)     wr_next = WR_DATA;
      end
      WR_ADDR:   if (w_hs)  wr_next = WR_COMMIT;
      WR_DATA:   if (aw_hs) wr_next = WR_COMMIT;
      WR_COMMIT: wr_next = s_axi_bready ? WR_IDLE : WR_RESP;
      WR_RESP:   if (s_axi_bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (s_axi_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  assign rd_idx = s_axi_araddr[ADDR_W-1:2];

  always_comb begin
    wr_is_ctrl   = (aw_idx_q == IW'(IDX_CTRL));
    wr_is_status = (aw_idx_q == IW'(IDX_STATUS));
    rd_is_ctrl   = (rd_idx == IW'(IDX_CTRL));
    rd_is_status = (rd_idx == IW'(IDX_STATUS));
    wr_is_cfg    = '0;
    rd_is_cfg    = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      wr_is_cfg[i] = (aw_idx_q == IW'(IDX_CFG0 + i));
      rd_is_cfg[i] = (rd_idx == IW'(IDX_CFG0 + i));
    end
    wr_mapped = wr_is_ctrl | wr_is_status | (|wr_is_cfg);
    rd_mapped = rd_is_ctrl | rd_is_status | (|rd_is_cfg);
  end

  assign s_axi_bresp = (s_axi_bvalid && !wr_mapped) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  axil_csr_regfile #(
    .DATA_W  (DATA_W),
    .NUM_CFG (NUM_CFG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_ctrl   (commit & wr_is_ctrl),
    .wr_status (commit & wr_is_status),
    .wr_cfg    ({NUM_CFG{commit}} & wr_is_cfg),
    .wr_data   (w_data_q),
    .wr_strb   (w_strb_q),
    .rd_ctrl   (rd_is_ctrl),
    .rd_status (rd_is_status),
    .rd_cfg    (rd_is_cfg),
    .rd_data   (rd_mux),
    .core_busy (core_busy_i),
    .core_done (core_done_i),
    .start     (start_o),
    .cfg       (cfg_regs)
`ifdef AXIL_CSR_IRQ_EN
    ,
    .irq       (irq_o)
`endif
  );

  assign cfg_o = cfg_regs;
endmodule
